// File: rtl/speaker_result_reporter_if.sv
`default_nettype none
// ============================================================================
// Module      : speaker_result_reporter_if
// Description : Byte-wide valid/ready handshake toward the UART transmitter.
//               master drives tx_valid/tx_data and samples tx_ready;
//               slave is the UART TX side.
// Ports       : tx_valid - a byte is being offered
//               tx_ready - the UART can take a byte this cycle
//               tx_data  - ASCII byte on offer
// Revision    : 1.0 - initial release
// ============================================================================
interface speaker_result_reporter_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );
endinterface
`default_nettype wire

// File: rtl/speaker_result_reporter.sv
`default_nettype none
// ============================================================================
// Module      : speaker_result_reporter
// Description : Captures the speaker recognition result, keeps the most
//               recent one for display, and, in UART reporting mode, sends
//               the six-byte ASCII report "SPK" + id + CR + LF over a
//               valid/ready byte interface.
// Ports       : clk, rst_n            - clock, async active-low reset
//               rs232_rx_data         - host command byte, [7:3] = mode
//               recognition_result    - speaker id or no-match code
//               recognition_result_flag - one-cycle result strobe
//               err_clr               - clears drop_err
//               tx (master)           - tx_valid / tx_ready / tx_data
//               last_result, result_valid - held result for display
//               busy                  - a report is in progress
//               drop_err              - sticky: flag arrived while busy
//               report_cnt            - completed reports, wraps at 255
// Revision    : 1.0 - initial release
// ============================================================================
module speaker_result_reporter #(
  parameter int unsigned SPEAKER_NUMBER = 4,
  parameter logic [2:0]  NO_RESULT_CODE = 3'b111,
  parameter logic [4:0]  MODE_CODE      = 5'b01011
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [7:0]                       rs232_rx_data,
  input  logic [2:0]                       recognition_result,
  input  logic                             recognition_result_flag,
  input  logic                             err_clr,
  speaker_result_reporter_if.master        tx,
  output logic [2:0]                       last_result,
  output logic                             result_valid,
  output logic                             busy,
  output logic                             drop_err,
  output logic [7:0]                       report_cnt
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_SEND  = 2'd1;
  localparam logic [1:0] c_ST_DONE  = 2'd2;

  localparam logic [2:0] c_LAST_IDX = 3'd5;

  localparam logic [7:0] c_CH_S     = 8'h53;
  localparam logic [7:0] c_CH_P     = 8'h50;
  localparam logic [7:0] c_CH_K     = 8'h4B;
  localparam logic [7:0] c_CH_ZERO  = 8'h30;
  localparam logic [7:0] c_CH_QUERY = 8'h3F;
  localparam logic [7:0] c_CH_CR    = 8'h0D;
  localparam logic [7:0] c_CH_LF    = 8'h0A;

  logic [1:0] r_state;
  logic [2:0] r_idx;
  logic [2:0] r_last_result;
  logic       r_result_valid;
  logic       r_drop_err;
  logic [7:0] r_report_cnt;
  logic       r_tx_valid;
  logic [7:0] r_tx_data;

  logic       w_mode_match;
  logic       w_id_known;
  logic [7:0] w_id_byte;
  logic [2:0] w_idx_next;
  logic [7:0] w_next_byte;
  logic       w_accept;
  logic       w_flag_dropped;
  logic       w_unused_rx;

  // Only the mode field of the host byte matters here.
  assign w_mode_match = (rs232_rx_data[7:3] == MODE_CODE);
  assign w_unused_rx  = ^rs232_rx_data[2:0];

  // The id byte always comes from the latched result so that a late or
  // changing input cannot corrupt a report already in flight.
  assign w_id_known = (r_last_result != NO_RESULT_CODE) &&
                      ({29'd0, r_last_result} < SPEAKER_NUMBER);
  assign w_id_byte  = w_id_known ? (c_CH_ZERO + {5'd0, r_last_result})
                                 : c_CH_QUERY;

  assign w_idx_next = r_idx + 3'd1;
  assign w_accept   = r_tx_valid && tx.tx_ready;

  // Byte for the index that follows an acceptance, so that the next byte
  // is registered in the same edge and there is no bubble between bytes.
  always_comb begin
    w_next_byte = c_CH_S;
    case (w_idx_next)
      3'd0:    w_next_byte = c_CH_S;
      3'd1:    w_next_byte = c_CH_P;
      3'd2:    w_next_byte = c_CH_K;
      3'd3:    w_next_byte = w_id_byte;
      3'd4:    w_next_byte = c_CH_CR;
      3'd5:    w_next_byte = c_CH_LF;
      default: w_next_byte = c_CH_S;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= c_ST_IDLE;
      r_idx          <= 3'd0;
      r_last_result  <= 3'd0;
      r_result_valid <= 1'b0;
      r_report_cnt   <= 8'd0;
      r_tx_valid     <= 1'b0;
      r_tx_data      <= 8'd0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (recognition_result_flag) begin
            r_last_result  <= recognition_result;
            r_result_valid <= 1'b1;
            if (w_mode_match) begin
              r_state    <= c_ST_SEND;
              r_idx      <= 3'd0;
              r_tx_valid <= 1'b1;
              r_tx_data  <= c_CH_S;
            end
          end
        end
        c_ST_SEND: begin
          if (w_accept) begin
            if (r_idx == c_LAST_IDX) begin
              r_state    <= c_ST_DONE;
              r_tx_valid <= 1'b0;
              r_idx      <= 3'd0;
            end else begin
              r_idx     <= w_idx_next;
              r_tx_data <= w_next_byte;
            end
          end
        end
        c_ST_DONE: begin
          r_report_cnt <= r_report_cnt + 8'd1;
          r_state      <= c_ST_IDLE;
        end
        default: begin
          r_state    <= c_ST_IDLE;
          r_tx_valid <= 1'b0;
          r_idx      <= 3'd0;
        end
      endcase
    end
  end

  // A flag outside IDLE is lost; setting wins over a simultaneous clear.
  assign w_flag_dropped = recognition_result_flag && (r_state != c_ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_err <= 1'b0;
    end else if (w_flag_dropped) begin
      r_drop_err <= 1'b1;
    end else if (err_clr) begin
      r_drop_err <= 1'b0;
    end
  end

  assign tx.tx_valid   = r_tx_valid;
  assign tx.tx_data    = r_tx_data;
  assign last_result   = r_last_result;
  assign result_valid  = r_result_valid;
  assign busy          = (r_state != c_ST_IDLE);
  assign drop_err      = r_drop_err;
  assign report_cnt    = r_report_cnt;

endmodule
`default_nettype wire

// File: tb/tb_speaker_result_reporter.sv
`default_nettype none
// ============================================================================
// Module      : tb_speaker_result_reporter
// Description : Directed self-checking bench for speaker_result_reporter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_speaker_result_reporter;

  logic       clk;
  logic       rst_n;
  logic [7:0] rs232_rx_data;
  logic [2:0] recognition_result;
  logic       recognition_result_flag;
  logic       err_clr;
  logic       tx_ready;
  logic [2:0] last_result;
  logic       result_valid;
  logic       busy;
  logic       drop_err;
  logic [7:0] report_cnt;

  int errors = 0;
  int checks = 0;

  logic [7:0] got [0:7];
  int         nbytes;
  int         busy_cycles;

  speaker_result_reporter_if txb ();
  assign txb.tx_ready = tx_ready;

  speaker_result_reporter dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .rs232_rx_data           (rs232_rx_data),
    .recognition_result      (recognition_result),
    .recognition_result_flag (recognition_result_flag),
    .err_clr                 (err_clr),
    .tx                      (txb),
    .last_result             (last_result),
    .result_valid            (result_valid),
    .busy                    (busy),
    .drop_err                (drop_err),
    .report_cnt              (report_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flag for one cycle with the given mode byte and result.
  task automatic start_flag(input logic [7:0] mode, input logic [2:0] res);
    rs232_rx_data           = mode;
    recognition_result      = res;
    recognition_result_flag = 1'b1;
    step();
    recognition_result_flag = 1'b0;
  endtask

  // Runs the link until busy drops, recording accepted bytes. pat 0 keeps
  // tx_ready high, pat 1 drives 1,0,0,1,0,0,... Optionally injects a
  // second flag (result 1, mode cleared) at cycle inject_at, with err_clr.
  task automatic collect(input int pat, input int inject_at, input logic inj_clr);
    logic [7:0] prev_data;
    logic       prev_pending;
    logic       finished;
    int         cyc;
    nbytes       = 0;
    busy_cycles  = 0;
    prev_pending = 1'b0;
    prev_data    = 8'd0;
    finished     = 1'b0;
    cyc          = 0;
    while (!finished && cyc < 60) begin
      if (!busy) begin
        finished = 1'b1;
      end else begin
        busy_cycles++;
        tx_ready = (pat == 0) ? 1'b1 : ((cyc % 3) == 0);
        if (cyc == inject_at) begin
          recognition_result      = 3'd1;
          recognition_result_flag = 1'b1;
          rs232_rx_data           = 8'h00;
          err_clr                 = inj_clr;
        end else begin
          recognition_result_flag = 1'b0;
          err_clr                 = 1'b0;
        end
        if (prev_pending) chk("hold_stable", {24'd0, txb.tx_data}, {24'd0, prev_data});
        if (txb.tx_valid && tx_ready) begin
          if (nbytes < 8) got[nbytes] = txb.tx_data;
          nbytes++;
        end
        prev_pending = txb.tx_valid && !tx_ready;
        prev_data    = txb.tx_data;
        step();
        cyc++;
      end
    end
    recognition_result_flag = 1'b0;
    err_clr                 = 1'b0;
    tx_ready                = 1'b1;
    if (!finished) chk("report_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_bytes(input string tag, input logic [7:0] id_byte);
    logic [7:0] exp [0:5];
    exp[0] = 8'h53; exp[1] = 8'h50; exp[2] = 8'h4B;
    exp[3] = id_byte; exp[4] = 8'h0D; exp[5] = 8'h0A;
    chk({tag, "_nbytes"}, nbytes, 32'd6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("%s_byte%0d", tag, k), {24'd0, got[k]}, {24'd0, exp[k]});
  endtask

  initial begin
    rst_n                   = 1'b0;
    rs232_rx_data           = 8'h00;
    recognition_result      = 3'd0;
    recognition_result_flag = 1'b0;
    err_clr                 = 1'b0;
    tx_ready                = 1'b0;
    step();
    step();
    // Reset state
    chk("rst_tx_valid",     {31'd0, txb.tx_valid}, 32'd0);
    chk("rst_tx_data",      {24'd0, txb.tx_data},  32'd0);
    chk("rst_last_result",  {29'd0, last_result},  32'd0);
    chk("rst_result_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_busy",         {31'd0, busy},         32'd0);
    chk("rst_drop_err",     {31'd0, drop_err},     32'd0);
    chk("rst_report_cnt",   {24'd0, report_cnt},   32'd0);
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    step();

    // Basic report, result 2, ready held high
    start_flag(8'h58, 3'd2);
    chk("t1_first_valid", {31'd0, txb.tx_valid}, 32'd1);
    chk("t1_first_data",  {24'd0, txb.tx_data},  32'h53);
    collect(0, -1, 1'b0);
    chk_bytes("t1", 8'h32);
    chk("t1_busy_cycles", busy_cycles, 32'd7);
    chk("t1_report_cnt",  {24'd0, report_cnt},  32'd1);
    chk("t1_last_result", {29'd0, last_result}, 32'd2);

    // No-match code and out-of-range id both report '?'
    start_flag(8'h58, 3'b111);
    collect(0, -1, 1'b0);
    chk_bytes("t2a", 8'h3F);
    start_flag(8'h58, 3'd5);
    collect(0, -1, 1'b0);
    chk_bytes("t2b", 8'h3F);
    chk("t2b_last_result", {29'd0, last_result}, 32'd5);
    chk("t2b_report_cnt",  {24'd0, report_cnt},  32'd3);

    // Back-pressure: ready pattern 1,0,0,1,...
    start_flag(8'h58, 3'd1);
    collect(1, -1, 1'b0);
    chk_bytes("t3", 8'h31);
    chk("t3_report_cnt", {24'd0, report_cnt}, 32'd4);

    // Flag dropped while byte 3 is on offer; mode also changes mid-report
    start_flag(8'h58, 3'd0);
    collect(0, 3, 1'b0);
    chk_bytes("t4", 8'h30);
    chk("t4_last_result", {29'd0, last_result}, 32'd0);
    chk("t4_drop_err",    {31'd0, drop_err},    32'd1);
    chk("t4_report_cnt",  {24'd0, report_cnt},  32'd5);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t4_drop_err_clr", {31'd0, drop_err}, 32'd0);

    // Dropped flag and err_clr together: set wins
    start_flag(8'h58, 3'd2);
    collect(0, 2, 1'b1);
    chk_bytes("t4b", 8'h32);
    chk("t4b_drop_err_set_wins", {31'd0, drop_err}, 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t4b_drop_err_clr", {31'd0, drop_err}, 32'd0);

    // Mode mismatch: capture only
    start_flag(8'h00, 3'd1);
    chk("t5_last_result",  {29'd0, last_result},  32'd1);
    chk("t5_result_valid", {31'd0, result_valid}, 32'd1);
    begin
      int saw_valid;
      saw_valid = 0;
      for (int k = 0; k < 10; k++) begin
        if (txb.tx_valid || busy) saw_valid++;
        step();
      end
      chk("t5_no_tx_valid", saw_valid, 32'd0);
    end
    chk("t5_report_cnt", {24'd0, report_cnt}, 32'd6);

    // Reset in the middle of a report
    start_flag(8'h58, 3'd3);
    step();
    step();
    chk("t6_byte2_on_offer", {24'd0, txb.tx_data}, 32'h4B);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_tx_valid", {31'd0, txb.tx_valid}, 32'd0);
    chk("t6_async_busy",     {31'd0, busy},         32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_tx_valid",     {31'd0, txb.tx_valid}, 32'd0);
    chk("t6_tx_data",      {24'd0, txb.tx_data},  32'd0);
    chk("t6_last_result",  {29'd0, last_result},  32'd0);
    chk("t6_result_valid", {31'd0, result_valid}, 32'd0);
    chk("t6_drop_err",     {31'd0, drop_err},     32'd0);
    chk("t6_report_cnt",   {24'd0, report_cnt},   32'd0);
    start_flag(8'h58, 3'd2);
    collect(0, -1, 1'b0);
    chk_bytes("t6_after", 8'h32);
    chk("t6_after_report_cnt", {24'd0, report_cnt}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
